logicn_unit: RTL
================

# logicn_unit

Parametrised, pipelined bitwise logic unit for the CPLD ALU datapath. Computes one of eight N-bit bitwise or reduction operations on two operands, with an optional accumulate mode that chains each result into the next operation. Result flags accompany every result. Input and output use valid/ready handshakes with a registered result stage and a skid buffer, so the block drops between operand latches and the ALU result mux without combinational ready paths.

## Interface
- N, 8: operand and result width in bits; N ≥ 2
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous and active-high
- in_valid  input  1  operand beat is present
- in_ready  output  1  block accepts a beat this cycle
- a  input  N  operand A
- b  input  N  operand B
- op  input  3  operation select; see Operation
- acc  input  1  when 1, the accumulator replaces A
- acc_clr  input  1  when 1 on an accepted beat, the accumulator is cleared to 0 after the op is evaluated
- out_valid  output  1  result beat is present
- out_ready  input  1  downstream accepts the result
- y  output  N  result
- z  output  1  y == 0
- ones  output  1  y is all ones
- par  output  1  XOR-reduction of y (odd parity)

## Operation
- Accept: a beat is accepted when in_valid && in_ready. A delivered result is one where out_valid && out_ready.
- Effective operand: ea = acc ? acc_q : a.
- op 0 AND: ea & b. op 1 NAND: ~(ea & b). op 2 OR: ea | b. op 3 NOR: ~(ea | b). op 4 XOR: ea ^ b. op 5 XNOR: ~(ea ^ b).
- op 6 NOTA: ~ea. B is ignored.
- op 7 RNAND: {N-1 zeros, ~&ea}. This is the N-wide reduction NAND, zero-extended.
- All results are exactly N bits. No carries are produced.
- Flags are computed from the final N-bit result and registered with it.
- Accumulator acc_q (N bits):
  - On every accepted beat, acc_q ← result. This applies whether acc is 0 or 1.
  - If acc_clr is 1 on that beat, acc_q ← 0 instead; the beat's result is still output normally.
  - acc_q does not change on cycles with no accepted beat.
- Datapath: the result is computed combinationally from the accepted beat and loaded into the output register.
  - The output register holds {y, z, ones, par} and out_valid.
  - If the output register is full and not draining, the beat goes into a one-entry skid register instead.
- State per stage: EMPTY, OUT_ONLY, OUT_AND_SKID.
  - EMPTY → OUT_ONLY on accept.
  - OUT_ONLY stays in OUT_ONLY on accept while delivering.
  - OUT_ONLY → EMPTY on deliver with no accept.
  - OUT_ONLY → OUT_AND_SKID on accept with no deliver.
  - OUT_AND_SKID → OUT_ONLY on deliver; the skid contents move into the output register.
  - in_ready = 0 only in OUT_AND_SKID.
- Ordering is strictly FIFO. No beat is dropped or duplicated.

## Timing
- Reset values: out_valid 0, y 0, z 0, ones 0, par 0, acc_q 0, skid empty, in_ready 1. Reset takes effect asynchronously.
- Reset mid-operation discards any held output and skid beat and clears acc_q.
- Latency: a beat accepted at edge k has out_valid = 1 after edge k, so it is visible in cycle k+1.
- Throughput: one beat per cycle while out_ready stays 1.
- in_ready is a registered output; it does not depend combinationally on out_ready.
- Simultaneous accept and deliver:
  - In OUT_ONLY, the new result replaces the delivered one in the same edge.
  - In OUT_AND_SKID, in_ready is 0, so accept cannot occur.
- Accumulate chaining: for back-to-back accepted beats with acc = 1, each beat uses the result of the immediately preceding accepted beat. This holds even while that result is stalled downstream.
- Outputs y, z, ones and par stay stable while out_valid && !out_ready.

## Structure
- Package logicn_pkg:
  - op encodings OP_AND=0 … OP_RNAND=7 as a 3-bit enum
  - state enum {EMPTY, OUT_ONLY, OUT_AND_SKID}
- Sub-module logicn_skid (parametrised by payload width N+3): owns the output register, the skid register and the handshake state machine.
- Top level: operand mux, op decode, flag generation and acc_q.

## Test plan
- Reset, then N=8, op 1, a=8'hF0, b=8'h3C, out_ready=1 → y=8'hCF, z=0, ones=0, par=0, one cycle after accept.
- op 7, a=8'hFF → y=8'h00, z=1. Then op 7, a=8'h7F → y=8'h01, par=1.
- Accumulate chain with acc=1: acc_clr beat first (op 2, a=x, b=8'h00), then op 2 b=8'h01, then op 2 b=8'h80, then op 4 b=8'hFF → y sequence ..., 8'h01, 8'h81, 8'h7E.
- Hold out_ready=0 and drive 3 beats with in_valid=1.
  - Expect: 2 beats accepted, in_ready=0 on the third.
  - Release out_ready → results delivered in order, third beat then accepted.
  - Outputs must stay stable while stalled.
- Random in_valid/out_ready toggling over 10k beats against a reference model → no loss, no duplication, results in order, acc chaining correct.
- Assert rst while in OUT_AND_SKID with acc_q=8'h5A → out_valid=0, in_ready=1, acc_q=0 immediately. The first beat afterwards with op 6, acc=1 → y=8'hFF.

Source files
------------

// File: rtl/logicn_pkg.sv
// -----------------------------------------------------------------------------
// logicn_pkg
// Shared types for the pipelined bitwise logic unit.
//   op_e          : 3-bit operation select, matches the op input encoding
//   skid_state_e  : occupancy of the result stage (output register + skid)
// -----------------------------------------------------------------------------
package logicn_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_NAND  = 3'd1,
        OP_OR    = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOTA  = 3'd6,
        OP_RNAND = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        EMPTY        = 2'd0,
        OUT_ONLY     = 2'd1,
        OUT_AND_SKID = 2'd2
    } skid_state_e;

    // Number of flag bits packed under the result: {z, ones, par}
    localparam int FLAG_W = 3;

endpackage

// File: rtl/logicn_skid.sv
// -----------------------------------------------------------------------------
// logicn_skid
// Registered result stage with a one-entry skid buffer. The output register
// is loaded from the accepted beat (or from the skid when the output drains),
// and in_ready is a flop so no combinational path runs from out_ready back
// to in_ready.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid      : upstream beat present
//   in_ready      : registered; low only while both output and skid are full
//   in_data [W]   : payload of the upstream beat
//   out_valid     : output register holds a beat
//   out_ready     : downstream takes the beat this cycle
//   out_data [W]  : payload held in the output register
// -----------------------------------------------------------------------------
module logicn_skid
    import logicn_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e r_state;
    skid_state_e w_state_nxt;

    logic [W-1:0] r_out_p1;
    logic [W-1:0] r_skid_p1;
    logic         r_in_ready;
    logic         r_out_valid;

    logic w_accept;
    logic w_deliver;
    logic w_load_out;
    logic w_load_from_skid;
    logic w_load_skid;

    assign w_accept  = in_valid & r_in_ready;
    assign w_deliver = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_out       = 1'b0;
        w_load_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_load_out  = 1'b1;
                    w_state_nxt = OUT_ONLY;
                end
            end
            OUT_ONLY: begin
                if (w_accept && w_deliver) begin
                    // new result replaces the one leaving in the same edge
                    w_load_out = 1'b1;
                end else if (w_accept) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = OUT_AND_SKID;
                end else if (w_deliver) begin
                    w_state_nxt = EMPTY;
                end
            end
            OUT_AND_SKID: begin
                // in_ready is low here, so only a drain can happen
                if (w_deliver) begin
                    w_load_from_skid = 1'b1;
                    w_state_nxt      = OUT_ONLY;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    // ---- stage boundary: result stage control ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != OUT_AND_SKID);
            r_out_valid <= (w_state_nxt != EMPTY);
        end
    end

    // ---- stage boundary: result stage data ----
    // Data is cleared on reset as well so a reset leaves y and flags at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_p1  <= '0;
            r_skid_p1 <= '0;
        end else begin
            if (w_load_out) begin
                r_out_p1 <= in_data;
            end else if (w_load_from_skid) begin
                r_out_p1 <= r_skid_p1;
            end
            if (w_load_skid) begin
                r_skid_p1 <= in_data;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_p1;

endmodule

// File: rtl/logicn_unit.sv
// -----------------------------------------------------------------------------
// logicn_unit
// Pipelined N-bit bitwise logic unit with accumulate mode and result flags.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : operand handshake (in_ready is registered)
//   a, b [N]        : operands
//   op [3]          : operation select (see logicn_pkg::op_e)
//   acc             : use the accumulator in place of a
//   acc_clr         : clear the accumulator after this beat is evaluated
//   out_valid/ready : result handshake
//   y [N]           : result
//   z, ones, par    : y == 0, y all ones, XOR-reduction of y
// -----------------------------------------------------------------------------
module logicn_unit
    import logicn_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    input  logic         acc,
    input  logic         acc_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         z,
    output logic         ones,
    output logic         par
);

    localparam int PW = N + FLAG_W;

    function automatic logic [N-1:0] f_logic_op(
        input op_e          i_op,
        input logic [N-1:0] i_ea,
        input logic [N-1:0] i_b
    );
        logic [N-1:0] res;
        res = '0;
        case (i_op)
            OP_AND:   res = i_ea & i_b;
            OP_NAND:  res = ~(i_ea & i_b);
            OP_OR:    res = i_ea | i_b;
            OP_NOR:   res = ~(i_ea | i_b);
            OP_XOR:   res = i_ea ^ i_b;
            OP_XNOR:  res = ~(i_ea ^ i_b);
            OP_NOTA:  res = ~i_ea;
            OP_RNAND: res = {{(N-1){1'b0}}, ~(&i_ea)};
            default:  res = '0;
        endcase
        return res;
    endfunction

    // {z, ones, par}
    function automatic logic [FLAG_W-1:0] f_flags(input logic [N-1:0] i_r);
        return {~(|i_r), &i_r, ^i_r};
    endfunction

    logic [N-1:0]  r_acc_q;
    logic [N-1:0]  w_ea;
    logic [N-1:0]  w_res_p0;
    logic [PW-1:0] w_payload_p0;
    logic [PW-1:0] w_out_p1;
    logic          w_in_ready;
    logic          w_accept;

    assign w_ea         = acc ? r_acc_q : a;
    assign w_res_p0     = f_logic_op(op_e'(op), w_ea, b);
    assign w_payload_p0 = {w_res_p0, f_flags(w_res_p0)};
    assign w_accept     = in_valid & w_in_ready;

    // ---- stage boundary: accumulator ----
    // Updated on accept, not on delivery, so chained beats see the previous
    // result even while it is stalled in the result stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_q <= '0;
        end else if (w_accept) begin
            r_acc_q <= acc_clr ? '0 : w_res_p0;
        end
    end

    logicn_skid #(
        .W (PW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .in_data   (w_payload_p0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_p1)
    );

    assign in_ready             = w_in_ready;
    assign {y, z, ones, par}    = w_out_p1;

endmodule
